reg_writeback_queue: RTL

Buffered write-back stage sitting in front of the register file's single write port. Accepts register-write requests from the ALU result path and the data-memory load path over valid/ready handshakes, holds them in an in-order queue, and drains one entry per cycle onto the register file's `RegWrite`/`WriteReg`/`WriteData` inputs. Also answers two combinational lookups so decode can forward the newest pending value or detect a pending write.

---
 rtl/reg_writeback_queue_pkg.sv | 24 ++
 rtl/reg_writeback_queue_match.sv | 42 ++++
 rtl/reg_writeback_queue.sv | 139 +++++++++++++
 3 files changed

// File: rtl/reg_writeback_queue_pkg.sv
// ---------------------------------------------------------------------------
// reg_writeback_queue_pkg
//   Types and constants shared by the write-back queue, the register file
//   and the hazard logic.
//   DATA_W     : register data width
//   ADDR_W     : register index width
//   wb_entry_t : one pending register write {rd, data}
//   is_live_reg: true for any index other than r0, which is hard-wired zero
// ---------------------------------------------------------------------------
package reg_writeback_queue_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic is_live_reg(input logic [ADDR_W-1:0] r);
        return r != '0;
    endfunction

endpackage

// File: rtl/reg_writeback_queue_match.sv
// ---------------------------------------------------------------------------
// wbq_match
//   Youngest-match search over the write-back queue storage.
//   ent_reg/ent_data : queue storage, indexed by physical slot
//   ent_valid        : per-slot occupied mask
//   head             : slot of the oldest entry
//   query            : register index to look up (index 0 never hits)
//   hit / data       : a pending write exists / newest pending data (0 on miss)
// ---------------------------------------------------------------------------
module wbq_match #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 5,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] ent_reg  [DEPTH],
    input  logic [DATA_W-1:0] ent_data [DEPTH],
    input  logic [DEPTH-1:0]  ent_valid,
    input  logic [PTR_W-1:0]  head,
    input  logic [ADDR_W-1:0] query,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic [PTR_W-1:0] idx;

    // Walk slots from oldest to youngest; later matches overwrite earlier
    // ones, so the result is the entry closest to the tail.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (ent_valid[idx] && (query != '0) && (ent_reg[idx] == query)) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// ---------------------------------------------------------------------------
// reg_writeback_queue
//   In-order buffer in front of the register file's single write port.
//   Loads (mem) and ALU results (alu) enqueue over valid/ready; the head
//   entry drains one per cycle onto RegWrite/WriteReg/WriteData.
//
//   clock, reset_n          : clock, asynchronous active-low reset
//   alu_valid/ready/reg/data: ALU write-request channel
//   mem_valid/ready/reg/data: load write-request channel (priority over alu)
//   wb_hold                 : stalls draining while high
//   RegWrite/WriteReg/WriteData : register file write port (head entry)
//   q_reg1/2 -> q_hit1/2, q_data1/2 : pending-write lookups for decode
//   count                   : occupied entries
//
//   Handshake: a request transfers on the rising edge where valid && ready.
//   Ready is a function of registered occupancy only (a same-cycle drain
//   does not open a slot), except that alu_ready is also masked by
//   mem_valid so that at most one enqueue happens per cycle. Requests to
//   r0 complete the handshake and are dropped.
// ---------------------------------------------------------------------------
module reg_writeback_queue #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = reg_writeback_queue_pkg::DATA_W,
    parameter  int ADDR_W = reg_writeback_queue_pkg::ADDR_W,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_hold,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] q_reg1,
    input  logic [ADDR_W-1:0] q_reg2,
    output logic              q_hit1,
    output logic              q_hit2,
    output logic [DATA_W-1:0] q_data1,
    output logic [DATA_W-1:0] q_data2,
    output logic [CNT_W-1:0]  count
);

    import reg_writeback_queue_pkg::*;

    logic [ADDR_W-1:0] ent_reg  [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  off;

    logic              not_full;
    logic              empty;
    logic              mem_fire;
    logic              alu_fire;
    logic              enq;
    logic              pop;
    logic [ADDR_W-1:0] enq_reg;
    logic [DATA_W-1:0] enq_data;

    assign not_full  = (count < CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign mem_ready = not_full;
    assign alu_ready = not_full && !mem_valid;

    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;

    // alu_fire implies !mem_valid, so the two never fire together.
    assign enq_reg   = mem_fire ? mem_reg  : alu_reg;
    assign enq_data  = mem_fire ? mem_data : alu_data;
    assign enq       = (mem_fire || alu_fire) && is_live_reg(enq_reg);

    assign RegWrite  = !empty && !wb_hold;
    assign pop       = RegWrite;
    assign WriteReg  = empty ? '0 : ent_reg[head];
    assign WriteData = empty ? '0 : ent_data[head];

    // A slot is occupied when its distance from head is below count.
    always_comb begin
        ent_valid = '0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = PTR_W'(i) - head;
            ent_valid[i] = (CNT_W'(off) < count);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i]  <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            if (enq) begin
                ent_reg[tail]  <= enq_reg;
                ent_data[tail] <= enq_data;
                tail           <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    wbq_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match1 (
        .ent_reg   (ent_reg),
        .ent_data  (ent_data),
        .ent_valid (ent_valid),
        .head      (head),
        .query     (q_reg1),
        .hit       (q_hit1),
        .data      (q_data1)
    );

    wbq_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match2 (
        .ent_reg   (ent_reg),
        .ent_data  (ent_data),
        .ent_valid (ent_valid),
        .head      (head),
        .query     (q_reg2),
        .hit       (q_hit2),
        .data      (q_data2)
    );

endmodule
